// File: rtl/sprite_rom_arbiter.sv
// Sprite mask ROM arbiter.
// Four sprite engines (player, ghost, dot, text overlay) share one mask ROM.
// A round-robin arbiter accepts one request at a time, issues a single ROM
// read, waits out the ROM latency and hands the captured row back to the
// requester that owns the access.
module sprite_rom_arbiter #(
    parameter int TILE_SIZE = 16,
    parameter int ROM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [15:0]          req_sprite,
    input  logic [15:0]          req_row,
    output logic [3:0]           gnt,
    output logic                 rom_en,
    output logic [7:0]           rom_addr,
    input  logic [TILE_SIZE-1:0] rom_data,
    output logic [3:0]           rsp_valid,
    output logic [TILE_SIZE-1:0] rsp_data,
    output logic                 busy
);

    // WAIT lasts ROM_LAT cycles, so the down-counter starts at ROM_LAT-1 and
    // the access completes on the edge where it reads zero (ROM_LAT <= 4).
    localparam logic [1:0] CNT_LOAD = 2'(ROM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [1:0] ptr;        // requester with highest priority next round
    logic [1:0] winner;     // owner of the access in flight
    logic [1:0] cnt;        // remaining WAIT cycles minus one
    logic [1:0] pick;       // combinational arbitration result
    logic       pick_vld;
    logic [1:0] idx;
    logic [3:0] winner_oh;

    // Round-robin search: first set req bit at or above ptr, wrapping mod 4.
    // Scanning offsets from high to low lets the smallest offset win last.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        idx      = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and Moore outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        gnt       = 4'd0;
        rom_en    = 1'b0;
        rsp_valid = 4'd0;
        busy      = 1'b1;
        winner_oh = 4'b0001 << winner;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (pick_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                gnt       = winner_oh;
                rom_en    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = winner_oh;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Access bookkeeping: latch the winner and its address when leaving IDLE,
    // count down the ROM latency, and capture the row on the last WAIT edge.
    // rom_addr only changes on a new grant so it holds between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 2'd0;
            winner   <= 2'd0;
            rom_addr <= 8'd0;
            cnt      <= 2'd0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        winner   <= pick;
                        ptr      <= pick + 2'd1;
                        rom_addr <= {req_sprite[{pick, 2'b00} +: 4],
                                     req_row[{pick, 2'b00} +: 4]};
                    end
                end
                ISSUE: begin
                    cnt <= CNT_LOAD;
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        rsp_data <= rom_data;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM_LAT 1 and 3) share one
// stimulus stream; each has its own transaction-level reference model and
// its own behavioural ROM with the matching read latency.
module tb_sprite_rom_arbiter;

    localparam int TS = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [15:0]   req_sprite;
    logic [15:0]   req_row;

    logic [3:0]    gnt_o      [2];
    logic          rom_en_o   [2];
    logic [7:0]    rom_addr_o [2];
    logic [TS-1:0] rom_data_i [2];
    logic [3:0]    rsp_valid_o[2];
    logic [TS-1:0] rsp_data_o [2];
    logic          busy_o     [2];

    always #5 clk = ~clk;

    sprite_rom_arbiter #(.TILE_SIZE(TS), .ROM_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_sprite(req_sprite), .req_row(req_row),
        .gnt(gnt_o[0]), .rom_en(rom_en_o[0]), .rom_addr(rom_addr_o[0]), .rom_data(rom_data_i[0]),
        .rsp_valid(rsp_valid_o[0]), .rsp_data(rsp_data_o[0]), .busy(busy_o[0])
    );

    sprite_rom_arbiter #(.TILE_SIZE(TS), .ROM_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_sprite(req_sprite), .req_row(req_row),
        .gnt(gnt_o[1]), .rom_en(rom_en_o[1]), .rom_addr(rom_addr_o[1]), .rom_data(rom_data_i[1]),
        .rsp_valid(rsp_valid_o[1]), .rsp_data(rsp_data_o[1]), .busy(busy_o[1])
    );

    // Behavioural ROMs: data appears ROM_LAT cycles after rom_en; garbage otherwise.
    logic [TS-1:0] mem [256];
    logic [TS-1:0] p0;
    logic [TS-1:0] p1 [3];

    always @(posedge clk) begin
        p0    <= rom_en_o[0] ? mem[rom_addr_o[0]] : TS'($urandom);
        p1[0] <= rom_en_o[1] ? mem[rom_addr_o[1]] : TS'($urandom);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end

    assign rom_data_i[0] = p0;
    assign rom_data_i[1] = p1[2];

    // Reference model state. age = cycles since the sampling edge of the
    // current access (0 = idle and sampling); grant seen at age 1, response
    // at age lat+2, idle again afterwards.
    int            lat [2] = '{1, 3};
    int            age [2];
    int            mptr[2];
    int            mwin[2];
    logic [7:0]    maddr[2];
    logic [TS-1:0] mpend[2];
    logic [TS-1:0] mdata[2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy1 = 0;

    logic [3:0] gq0[$];
    int         gc0[$];
    int         rc0[$];
    int         gc1[$];
    int         rc1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic clear_log();
        gq0.delete(); gc0.delete(); rc0.delete(); gc1.delete(); rc1.delete();
        busy1 = 0;
    endtask

    task automatic check_dut(input int d);
        logic [3:0] eg;
        logic [3:0] er;
        eg = (age[d] == 1) ? 4'(1 << mwin[d]) : 4'd0;
        er = (age[d] == lat[d] + 2) ? 4'(1 << mwin[d]) : 4'd0;
        chk($sformatf("gnt%0d c%0d", d, cyc), 32'(gnt_o[d]), 32'(eg));
        chk($sformatf("rom_en%0d c%0d", d, cyc), 32'(rom_en_o[d]), 32'(age[d] == 1));
        chk($sformatf("rom_addr%0d c%0d", d, cyc), 32'(rom_addr_o[d]), 32'(maddr[d]));
        chk($sformatf("rsp_valid%0d c%0d", d, cyc), 32'(rsp_valid_o[d]), 32'(er));
        chk($sformatf("rsp_data%0d c%0d", d, cyc), 32'(rsp_data_o[d]), 32'(mdata[d]));
        chk($sformatf("busy%0d c%0d", d, cyc), 32'(busy_o[d]), 32'(age[d] != 0));
        if (d == 0) begin
            if (gnt_o[0] != 4'd0) begin gq0.push_back(gnt_o[0]); gc0.push_back(cyc); end
            if (rsp_valid_o[0] != 4'd0) rc0.push_back(cyc);
        end else begin
            if (gnt_o[1] != 4'd0) gc1.push_back(cyc);
            if (rsp_valid_o[1] != 4'd0) rc1.push_back(cyc);
            if (busy_o[1]) busy1++;
        end
    endtask

    // One clock cycle: check, drive new inputs, advance models, wait a cycle.
    task automatic cycle(input logic [3:0] r, input logic [15:0] s, input logic [15:0] w);
        check_dut(0);
        check_dut(1);
        req        = r;
        req_sprite = s;
        req_row    = w;
        for (int d = 0; d < 2; d++) begin
            if (age[d] == 0) begin
                if (r != 4'd0) begin
                    mwin[d]  = rr_pick(r, mptr[d]);
                    mptr[d]  = (mwin[d] + 1) % 4;
                    maddr[d] = {s[4*mwin[d] +: 4], w[4*mwin[d] +: 4]};
                    mpend[d] = mem[maddr[d]];
                    age[d]   = 1;
                end
            end else if (age[d] == lat[d] + 2) begin
                age[d] = 0;
            end else begin
                age[d] = age[d] + 1;
                if (age[d] == lat[d] + 2) mdata[d] = mpend[d];
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s gnt%0d", tag, d), 32'(gnt_o[d]), 32'd0);
            chk($sformatf("%s rom_en%0d", tag, d), 32'(rom_en_o[d]), 32'd0);
            chk($sformatf("%s rom_addr%0d", tag, d), 32'(rom_addr_o[d]), 32'd0);
            chk($sformatf("%s rsp_valid%0d", tag, d), 32'(rsp_valid_o[d]), 32'd0);
            chk($sformatf("%s rsp_data%0d", tag, d), 32'(rsp_data_o[d]), 32'd0);
            chk($sformatf("%s busy%0d", tag, d), 32'(busy_o[d]), 32'd0);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            age[d] = 0; mptr[d] = 0; mwin[d] = 0; maddr[d] = 8'd0; mdata[d] = '0; mpend[d] = '0;
        end
    endtask

    // Asynchronous reset mid-cycle: outputs must drop before any clock edge.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_rr[5];
        logic [3:0] r;
        exp_rr     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n      = 1'b0;
        req        = 4'd0;
        req_sprite = 16'd0;
        req_row    = 16'd0;
        for (int i = 0; i < 256; i++) mem[i] = TS'($urandom);
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Single request, sprite 3 row 5 from the player lane
        clear_log();
        cycle(4'b0001, 16'hABC3, 16'h9875);
        chk("single gnt", 32'(gnt_o[0]), 32'h1);
        chk("single rom_en", 32'(rom_en_o[0]), 32'h1);
        chk("single addr", 32'(rom_addr_o[0]), 32'h35);
        cycle(4'b0000, 16'h0, 16'h0);
        cycle(4'b0000, 16'h0, 16'h0);
        chk("single rsp_valid", 32'(rsp_valid_o[0]), 32'h1);
        chk("single rsp_data", 32'(rsp_data_o[0]), 32'(mem[8'h35]));
        repeat (5) cycle(4'b0000, 16'h0, 16'h0);
        chk("single rsp count", 32'(rc0.size()), 32'd1);

        // ROM_LAT=3 instance on the same request
        chk("lat3 rsp seen", 32'(rc1.size() == 1 && gc1.size() == 1), 32'd1);
        if (rc1.size() == 1 && gc1.size() == 1)
            chk("lat3 gnt->rsp", 32'(rc1[0] - gc1[0]), 32'd4);
        chk("lat3 busy cycles", 32'(busy1), 32'd5);

        // Round robin with all requesters held
        pulse_reset();
        clear_log();
        repeat (20) cycle(4'b1111, 16'($urandom), 16'($urandom));
        repeat (6) cycle(4'b0000, 16'h0, 16'h0);
        chk("rr count", 32'(gq0.size()), 32'd5);
        if (gq0.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("rr order %0d", i), 32'(gq0[i]), 32'(exp_rr[i]));
            for (int i = 1; i < 5; i++) chk($sformatf("rr spacing %0d", i), 32'(gc0[i] - gc0[i-1]), 32'd4);
        end

        // Fairness after wrap: grant requester 2 so ptr=3, then 1001
        cycle(4'b0100, 16'h1234, 16'h5678);
        repeat (6) cycle(4'b0000, 16'h0, 16'h0);
        clear_log();
        repeat (8) cycle(4'b1001, 16'hF00E, 16'h7001);
        repeat (6) cycle(4'b0000, 16'h0, 16'h0);
        chk("wrap count", 32'(gq0.size() >= 2), 32'd1);
        if (gq0.size() >= 2) begin
            chk("wrap first", 32'(gq0[0]), 32'b1000);
            chk("wrap second", 32'(gq0[1]), 32'b0001);
        end

        // Reset in WAIT discards the access; pointer restarts at 0
        cycle(4'b0001, 16'h0042, 16'h0007);
        cycle(4'b0000, 16'h0, 16'h0);
        chk("pre-reset in WAIT", 32'(busy_o[0] && !gnt_o[0] && !rsp_valid_o[0]), 32'd1);
        pulse_reset();
        clear_log();
        repeat (5) cycle(4'b0000, 16'h0, 16'h0);
        chk("no rsp after reset", 32'(rc0.size() + rc1.size()), 32'd0);
        cycle(4'b0100, 16'h0900, 16'h0A00);
        chk("post-reset gnt", 32'(gnt_o[0]), 32'b0100);
        chk("post-reset addr", 32'(rom_addr_o[0]), 32'h9A);
        repeat (6) cycle(4'b0000, 16'h0, 16'h0);
        pulse_reset();
        cycle(4'b1001, 16'h0, 16'h0);
        chk("ptr zero after reset", 32'(gnt_o[0]), 32'b0001);
        repeat (6) cycle(4'b0000, 16'h0, 16'h0);

        // Withdrawal before the sampling edge
        clear_log();
        req = 4'b0010;
        #2;
        repeat (3) cycle(4'b0000, 16'h0, 16'h0);
        chk("withdrawn no gnt", 32'(gq0.size() + gc1.size()), 32'd0);

        // Request rising during WAIT waits for the next IDLE
        clear_log();
        cycle(4'b0001, 16'h0001, 16'h0002);
        cycle(4'b0000, 16'h0, 16'h0);
        repeat (4) cycle(4'b0100, 16'h0B00, 16'h0C00);
        repeat (6) cycle(4'b0000, 16'h0, 16'h0);
        chk("late req grants", 32'(gq0.size() >= 2 && rc0.size() >= 1), 32'd1);
        if (gq0.size() >= 2 && rc0.size() >= 1) begin
            chk("late req order", 32'(gq0[1]), 32'b0100);
            chk("late req timing", 32'(gc0[1] - rc0[0]), 32'd2);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'd0;
            cycle(r, 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 149) == 0) pulse_reset();
        end
        repeat (6) cycle(4'b0000, 16'h0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
